// File: rtl/ram_wait_ctrl.sv
// ram_wait_ctrl: word-addressed RAM with LAT BUSY wait states then one ACCESS cycle; optional `RAM_STATS_EN adds rd_count/wr_count
package cpu_types_pkg;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

module ram_wait_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LAT    = 2,
  parameter int unsigned ADDR_W = 10
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ramREN,
  input  logic        ramWEN,
  input  logic [31:0] ramaddr,
  input  logic [31:0] ramstore,
  output logic [31:0] ramload,
`ifdef RAM_STATS_EN
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
`endif
  output ramstate_t   ramstate
);
  typedef enum logic [1:0] {IDLE, WAIT, ACC, ERR} state_t;
  state_t state, n_state;
  ramstate_t n_ramstate;
  logic [3:0] cnt, n_cnt;
  logic lat_ren, lat_wen, n_ren, n_wen;
  logic [ADDR_W-1:0] idx, lat_idx, n_idx;
  logic [31:0] lat_store, n_store;
  logic [31:0] mem [2**ADDR_W];
  logic aligned, in_range, any_en, valid, illegal, changed, take, fwd;
  assign idx      = ramaddr[ADDR_W+1:2];
  assign aligned  = ramaddr[1:0] == 2'b00;
  assign in_range = ramaddr[31:ADDR_W+2] == '0;
  assign any_en   = ramREN | ramWEN;
  assign valid    = (ramREN ^ ramWEN) & aligned & in_range;
  assign illegal  = (ramREN & ramWEN) | (any_en & ~(aligned & in_range));
  assign changed  = (ramREN != lat_ren) | (ramWEN != lat_wen) | (idx != lat_idx) |
                    (ramWEN & (ramstore != lat_store));
  // A write completing this cycle must be seen by a read captured at the same edge
  assign fwd      = (state == ACC) & lat_wen & (lat_idx == n_idx);
  // Next-state: WAIT counts down or restarts on changed inputs; IDLE/ACC/ERR all decode a fresh request
  always_comb begin
    n_state = state;
    n_cnt   = cnt;
    n_ren   = lat_ren;
    n_wen   = lat_wen;
    n_idx   = lat_idx;
    n_store = lat_store;
    take    = 1'b0;
    if (state == WAIT) begin
      if (!any_en) n_state = IDLE;
      else if (illegal) n_state = ERR;
      else if (changed) take = 1'b1;
      else begin
        n_cnt   = cnt - 4'd1;
        n_state = (cnt == 4'd1) ? ACC : WAIT;
      end
    end else begin
      take    = valid;
      n_state = illegal ? ERR : IDLE;
    end
    if (take) begin
      n_ren   = ramREN;
      n_wen   = ramWEN;
      n_idx   = idx;
      n_store = ramstore;
      n_cnt   = 4'(LAT);
      n_state = (LAT == 0) ? ACC : WAIT;
    end
    n_ramstate = (n_state == WAIT) ? BUSY : (n_state == ACC) ? ACCESS :
                 (n_state == ERR) ? ERROR : FREE;
  end
  // State, latched request and registered outputs; read data captured on entry to ACC
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ramstate  <= FREE;
      cnt       <= '0;
      lat_ren   <= 1'b0;
      lat_wen   <= 1'b0;
      lat_idx   <= '0;
      lat_store <= '0;
      ramload   <= '0;
    end else begin
      state     <= n_state;
      ramstate  <= n_ramstate;
      cnt       <= n_cnt;
      lat_ren   <= n_ren;
      lat_wen   <= n_wen;
      lat_idx   <= n_idx;
      lat_store <= n_store;
      if (n_state == ACC && n_ren) ramload <= fwd ? lat_store : mem[n_idx];
    end
  end
  // Memory array is never reset; a write commits at the edge ending its ACC cycle
  always_ff @(posedge CLK) begin
    if (state == ACC && lat_wen) mem[lat_idx] <= lat_store;
  end
`ifdef RAM_STATS_EN
  // Saturating completion counters, one per access type
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == ACC) begin
      if (lat_ren && rd_count != '1) rd_count <= rd_count + 32'd1;
      if (lat_wen && wr_count != '1) wr_count <= wr_count + 32'd1;
    end
  end
`endif
endmodule
